// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for a multicycle MIPS-style datapath
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   Opcode[5:0]             instruction bits [31:26] from the instruction register
//   MemReady                current memory access completes this cycle
//   PCWrite .. RegDst       single-bit datapath controls
//   ALUOp[1:0]              00 add, 01 sub, 10 decode funct
//   ALUSrcB[1:0]            00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2
//   PCSource[1:0]           00 ALU result, 01 ALUOut, 10 jump target
//   State[3:0]              current state code (debug)
//   IllegalOp               unsupported opcode seen in DECODE
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [1:0] ALUOp,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [3:0] State,
   output logic       IllegalOp
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   state_t state, next_state;

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_FETCH;
      else
         state <= next_state;
   end

   assign State = state;

   always_comb begin
      next_state  = S_FETCH;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUOp       = 2'b00;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      IllegalOp   = 1'b0;

      if (reset) begin
         // Hold FETCH's non-strobe values so the datapath looks like an idle
         // fetch, but keep every write/read strobe quiet until reset drops.
         ALUSrcB = 2'b01;
      end else begin
         case (state)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               // IR and PC update only on the cycle the fetch actually completes.
               IRWrite = MemReady;
               PCWrite = MemReady;
               next_state = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
               ALUSrcB = 2'b11;
               ALUOp   = 2'b00;
               case (Opcode)
                  OP_LW, OP_SW: next_state = S_MEMADR;
                  OP_RTYPE:     next_state = S_EXEC;
                  OP_BEQ:       next_state = S_BRANCH;
                  OP_J:         next_state = S_JUMP;
                  OP_ADDI:      next_state = S_ADDIEX;
                  default: begin
                     next_state = S_FETCH;
                     IllegalOp  = 1'b1;
                  end
               endcase
            end
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               next_state = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
               next_state = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            S_MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
               next_state = MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
               next_state = S_RWB;
            end
            S_RWB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'b01;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
            end
            S_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
            end
            S_ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
               RegWrite = 1'b1;
            end
            // Codes 12-15 are unreachable in normal operation; recover to FETCH.
            default: next_state = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Opcode;
   logic       MemReady;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
   logic       IRWrite, ALUSrcA, RegWrite, RegDst, IllegalOp;
   logic [1:0] ALUOp, ALUSrcB, PCSource;
   logic [3:0] State;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
      .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
      .PCSource(PCSource), .State(State), .IllegalOp(IllegalOp)
   );

   // Control vector order:
   // PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite ALUSrcA RegWrite RegDst
   // ALUOp[1:0] ALUSrcB[1:0] PCSource[1:0] IllegalOp
   logic [16:0] ctrl;
   assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                  IRWrite, ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, IllegalOp};

   localparam logic [16:0] C_RST  = 17'b0000000000_00_01_00_0;
   localparam logic [16:0] C_F1   = 17'b1001001000_00_01_00_0;
   localparam logic [16:0] C_F0   = 17'b0001000000_00_01_00_0;
   localparam logic [16:0] C_DEC  = 17'b0000000000_00_11_00_0;
   localparam logic [16:0] C_DECI = 17'b0000000000_00_11_00_1;
   localparam logic [16:0] C_MADR = 17'b0000000100_00_10_00_0;
   localparam logic [16:0] C_MRD  = 17'b0011000000_00_00_00_0;
   localparam logic [16:0] C_MWB  = 17'b0000010010_00_00_00_0;
   localparam logic [16:0] C_MWR  = 17'b0010100000_00_00_00_0;
   localparam logic [16:0] C_EXE  = 17'b0000000100_10_00_00_0;
   localparam logic [16:0] C_RWB  = 17'b0000000011_00_00_00_0;
   localparam logic [16:0] C_BR   = 17'b0100000100_01_00_01_0;
   localparam logic [16:0] C_JMP  = 17'b1000000000_00_00_10_0;
   localparam logic [16:0] C_AEX  = 17'b0000000100_00_10_00_0;
   localparam logic [16:0] C_AWB  = 17'b0000000010_00_00_00_0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply inputs for one cycle, check the Moore outputs, then advance one edge.
   task automatic cyc(input string tag, input logic rst, input logic mr, input logic [5:0] op,
                      input logic [3:0] exp_state, input logic [16:0] exp_ctrl);
      reset    = rst;
      MemReady = mr;
      Opcode   = op;
      #1;
      check({tag, "_state"}, {28'd0, State}, {28'd0, exp_state});
      check({tag, "_ctrl"}, {15'd0, ctrl}, {15'd0, exp_ctrl});
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; MemReady = 1'b0; Opcode = 6'd0;
      @(posedge clk);
      #1;
      cyc("rst_hold", 1, 1, 6'd35, 4'd0, C_RST);

      // lw, no waits: 0,1,2,3,4 then back to 0
      cyc("lw_fetch",  0, 1, 6'd35, 4'd0, C_F1);
      cyc("lw_decode", 0, 1, 6'd35, 4'd1, C_DEC);
      cyc("lw_memadr", 0, 1, 6'd35, 4'd2, C_MADR);
      cyc("lw_memrd",  0, 1, 6'd35, 4'd3, C_MRD);
      cyc("lw_memwb",  0, 1, 6'd0,  4'd4, C_MWB);

      // sw with two wait cycles in MEMWR; opcode changes there must be ignored
      cyc("sw_fetch",  0, 1, 6'd43, 4'd0, C_F1);
      cyc("sw_decode", 0, 1, 6'd43, 4'd1, C_DEC);
      cyc("sw_memadr", 0, 1, 6'd43, 4'd2, C_MADR);
      cyc("sw_wait0",  0, 0, 6'd35, 4'd5, C_MWR);
      cyc("sw_wait1",  0, 0, 6'd0,  4'd5, C_MWR);
      cyc("sw_done",   0, 1, 6'd43, 4'd5, C_MWR);

      // fetch wait, then R-type
      cyc("r_fwait",   0, 0, 6'd0, 4'd0, C_F0);
      cyc("r_fetch",   0, 1, 6'd0, 4'd0, C_F1);
      cyc("r_decode",  0, 1, 6'd0, 4'd1, C_DEC);
      cyc("r_exec",    0, 1, 6'd0, 4'd6, C_EXE);
      cyc("r_rwb",     0, 1, 6'd0, 4'd7, C_RWB);

      // addi
      cyc("ai_fetch",  0, 1, 6'd8, 4'd0,  C_F1);
      cyc("ai_decode", 0, 1, 6'd8, 4'd1,  C_DEC);
      cyc("ai_ex",     0, 1, 6'd8, 4'd10, C_AEX);
      cyc("ai_wb",     0, 1, 6'd8, 4'd11, C_AWB);

      // beq
      cyc("beq_fetch",  0, 1, 6'd4, 4'd0, C_F1);
      cyc("beq_decode", 0, 1, 6'd4, 4'd1, C_DEC);
      cyc("beq_branch", 0, 1, 6'd4, 4'd8, C_BR);

      // j
      cyc("j_fetch",  0, 1, 6'd2, 4'd0, C_F1);
      cyc("j_decode", 0, 1, 6'd2, 4'd1, C_DEC);
      cyc("j_jump",   0, 1, 6'd2, 4'd9, C_JMP);

      // illegal opcode: one flagged DECODE cycle, then a fetch that waits
      cyc("ill_fetch",  0, 1, 6'd63, 4'd0, C_F1);
      cyc("ill_decode", 0, 1, 6'd63, 4'd1, C_DECI);
      cyc("ill_after",  0, 0, 6'd63, 4'd0, C_F0);

      // reset during a stalled memory read
      cyc("mr_fetch",  0, 1, 6'd35, 4'd0, C_F1);
      cyc("mr_decode", 0, 1, 6'd35, 4'd1, C_DEC);
      cyc("mr_memadr", 0, 1, 6'd35, 4'd2, C_MADR);
      cyc("mr_stall",  0, 0, 6'd35, 4'd3, C_MRD);
      cyc("mr_rst0",   1, 0, 6'd35, 4'd3, C_RST);
      cyc("mr_rst1",   1, 0, 6'd35, 4'd0, C_RST);
      cyc("mr_resume", 0, 1, 6'd35, 4'd0, C_F1);
      cyc("mr_next",   0, 1, 6'd35, 4'd1, C_DEC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001: The block SHALL have one clock and a synchronous, active-high reset, with clock port clk and reset port reset.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004: Opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005: MemReady  input  1  memory completion; high means the current memory access finishes this cycle.
REQ-006: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  standard multicycle datapath controls.
REQ-007: ALUOp  output  2  selects the ALU operation class for the downstream ALU control stage: 00 add, 01 sub, 10 decode funct.
REQ-008: ALUSrcB  output  2  ALU B select: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2.
REQ-009: PCSource  output  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-010: State  output  4  current state encoding, for debug.
REQ-011: IllegalOp  output  1  flags an unsupported opcode.

Function
REQ-012: The block SHALL be a Moore FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-013: Any output not listed for a state SHALL be 0 in that state.
REQ-014: FETCH: MemRead=1, ALUSrcB=01; IRWrite and PCWrite SHALL equal MemReady. Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
REQ-015: DECODE: ALUSrcB=11, ALUOp=00. Next state by Opcode:
- 35 (lw) or 43 (sw) -> MEMADR
- 0 (R-type) -> EXEC
- 4 (beq) -> BRANCH
- 2 (j) -> JUMP
- 8 (addi) -> ADDIEX
- any other value -> FETCH, with IllegalOp=1 for that DECODE cycle only.
REQ-016: MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if Opcode=35, else MEMWR.
REQ-017: MEMRD: MemRead=1, IorD=1. Stay while MemReady=0; go to MEMWB when MemReady=1.
REQ-018: MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; then FETCH.
REQ-019: MEMWR: MemWrite=1, IorD=1. Stay while MemReady=0; go to FETCH when MemReady=1.
REQ-020: EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; then RWB.
REQ-021: RWB: RegWrite=1, RegDst=1, MemtoReg=0; then FETCH.
REQ-022: BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; then FETCH.
REQ-023: JUMP: PCWrite=1, PCSource=10; then FETCH.
REQ-024: ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; then ADDIWB.
REQ-025: ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; then FETCH.
REQ-026: All outputs SHALL be combinational functions of State, plus MemReady in FETCH and Opcode in DECODE; only the state register is sequential.
REQ-027: Opcode SHALL be ignored in every state except DECODE and MEMADR.
REQ-028: Instruction latency in cycles, with zero memory wait:
- lw 5
- sw 4
- R-type 4
- addi 4
- beq 3
- j 3
Each memory wait cycle adds one cycle.

Reset
REQ-029: While reset=1 at a rising edge, the next state SHALL be FETCH, regardless of the current state or any in-progress memory wait.
REQ-030: While reset is asserted, PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead and IllegalOp SHALL be forced to 0; all other outputs SHALL take their FETCH values.
REQ-031: On the first edge after reset deasserts, the FSM SHALL behave as a normal FETCH; no write strobe SHALL be produced before that edge.

Verification
REQ-032: lw, MemReady=1 throughout: Opcode=35 -> States 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-033: sw with 2 wait cycles: Opcode=43, MemReady low for 2 cycles in MEMWR -> State stays 5 for 3 cycles; MemWrite=1 and IorD=1 for all 3; then State=0.
REQ-034: R-type: Opcode=0 -> ALUOp=10 in EXEC; RegDst=1 and RegWrite=1 in RWB; 4 cycles total.
REQ-035: beq/j: Opcode=4 -> ALUOp=01, PCWriteCond=1, PCSource=01 in state 8; Opcode=2 -> PCWrite=1, PCSource=10 in state 9; both return to FETCH.
REQ-036: Illegal opcode: Opcode=63 in DECODE -> IllegalOp=1 for exactly one cycle; State returns to 0; no write strobes asserted.
REQ-037: Reset mid-access: reset=1 while State=3 and MemReady=0 -> State=0 next cycle, MemRead=0 while reset is held; normal FETCH resumes after reset deasserts.
